usart_tx_arbiter: RTL and testbench
===================================

Name: usart_tx_arbiter

Overview:
- Shares one USART transmitter (byte-wide `usart_tx`, clocked by the slow `bit_clock_x1`) among NUM_REQ byte producers in the comm_clock domain.
- Grants requesters round-robin and latches the granted byte into the transmitter.
- Tracks the transmitter's ready line through a synchronizer and reports per-requester acceptance and completion.
- Sits between the `usart_echo`/CPU-side producers and the transmitter.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- SYNC_STAGES, 2: flops on the tx_ready synchronizer, ≥2.
- LATCH_TIMEOUT, 4095: comm_clock cycles to wait for the transmitter to go busy before aborting, 1..65535.

Ports:
- comm_clock  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  NUM_REQ  requester i has a byte pending.
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_ack  output  NUM_REQ  one-cycle pulse: byte captured; requester may change data.
- req_done  output  NUM_REQ  one-cycle pulse: byte fully shifted out.
- grant_id  output  3  index of the current or last granted requester.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  sticky; set on latch timeout.
- tx_data  output  8  to the transmitter's data_in.
- tx_latch  output  1  to the transmitter's latch_in.
- tx_ready  input  1  from the transmitter, asynchronous to comm_clock; high means idle.

Behaviour:
- Reset state: IDLE. All outputs are 0, tx_data=0, the RR pointer is 0 (requester 0 has highest priority), timeout_err=0, the timeout counter is 0.
- Reset mid-transfer abandons the byte immediately and drops tx_latch on the next edge. No ack or done is emitted.
- tx_ready passes through SYNC_STAGES flops; rdy_s is the synchronized value. Every use of tx_ready below means rdy_s.
- States: IDLE, LATCH, WAIT_DONE.
- IDLE:
  - Move on only if some req_valid is set and rdy_s=1.
  - Winner = first set bit scanning from ptr upward, wrapping modulo NUM_REQ.
  - Same edge: tx_data<=req_data[winner], grant_id<=winner, req_ack[winner] pulses for 1 cycle, ptr<=(winner+1) mod NUM_REQ, counter cleared, go to LATCH.
  - Grant latency from req_valid high (with rdy_s=1) is 1 cycle.
- LATCH:
  - tx_latch=1 and tx_data is held.
  - If rdy_s=0, go to WAIT_DONE with tx_latch=0.
  - Otherwise the counter increments. When it reaches LATCH_TIMEOUT, set timeout_err, drop tx_latch and return to IDLE with no done pulse.
- WAIT_DONE:
  - When rdy_s=1, pulse req_done[grant_id] and go to IDLE.
  - The next grant can happen no earlier than the cycle after that.
- tx_data changes only on the IDLE→LATCH edge.
- req_valid deasserting after ack has no effect on the transfer in progress.
- A requester that keeps req_valid high is re-granted only after all other active requesters have been served (strict RR, no starvation).
- Only one ack and one done are ever high in any cycle.
- timeout_err clears only on reset.
- Counter width is $clog2(LATCH_TIMEOUT+1); it saturates and does not wrap.

Optional Feature:
- Macro: USART_TX_ARB_LOCK_EN.
- When defined, an extra input `req_lock` [NUM_REQ] is added.
- If req_lock[grant_id]=1 in the cycle req_done pulses, the next IDLE selection gives grant_id absolute priority, provided its req_valid is set. This keeps multi-byte frames contiguous.
- The pointer still advances normally once the lock drops.
- When not defined: pure round-robin and no such port.

Decomposition:
- Package usart_pkg holds:
  - state encoding localparams (IDLE=2'd0, LATCH=2'd1, WAIT_DONE=2'd2)
  - USART_BYTE_W=8
  - the default timeout constant
- One sub-module, usart_rr_pick:
  - inputs: req vector and ptr
  - outputs: winner index and a found flag
  - combinational rotate-priority-encode, reusable by a future RX dispatcher.
- The synchronizer is inline.

Test Plan:
- Reset, then req_valid=4'b0001, data 8'hA5, tx_ready model idle → ack[0] after 1 cycle; tx_latch high until the model drops ready; tx_data=8'hA5; done[0] when ready returns; busy low afterwards.
- All four requesters valid continuously (data 8'h10..8'h13) → grant order 0,1,2,3,0; exactly one ack per byte.
- ptr=2 (after serving 1), requests 4'b0011 → grant 0 before 1 (wrap-around).
- Model holds tx_ready=1 forever with LATCH_TIMEOUT=8 → tx_latch drops 8 cycles after entering LATCH; timeout_err=1 and stays; no done; next request is still serviced.
- Reset pulse while in WAIT_DONE → state IDLE, tx_latch=0, no done; ptr=0 so requester 0 wins next.
- With USART_TX_ARB_LOCK_EN: req_lock[1]=1, requesters 1 and 2 valid → three consecutive grants to 1; after the lock drops, 2 is granted.

Source files
------------

// File: rtl/usart_pkg.sv
// Shared types and constants for the USART transmit arbiter and its
// round-robin picker.
package usart_pkg;

    localparam int USART_BYTE_W            = 8;
    localparam int USART_ID_W              = 3;
    localparam int USART_LATCH_TIMEOUT_DEF = 4095;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LATCH     = 2'd1,
        WAIT_DONE = 2'd2
    } usart_state_e;

endpackage

// File: rtl/usart_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr_i, wrapping
// modulo NUM_REQ.
module usart_rr_pick
    import usart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [USART_ID_W-1:0] ptr_i,
    output logic [USART_ID_W-1:0] winner_o,
    output logic                  found_o
);

    logic [NUM_REQ-1:0] rot;

    always_comb begin
        rot      = NUM_REQ'({req_i, req_i} >> ptr_i);
        found_o  = 1'b0;
        winner_o = '0;
        // Scan downward so the lowest rotated offset is the one that sticks.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o  = 1'b1;
                winner_o = USART_ID_W'((int'(ptr_i) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter sharing one USART transmitter among NUM_REQ producers.
// Define USART_TX_ARB_LOCK_EN to add req_lock for contiguous multi-byte frames.
//
// state     | meaning
// IDLE      | waiting for a request while the transmitter reports ready
// LATCH     | tx_latch held, waiting for the transmitter to go busy
// WAIT_DONE | byte shifting out, waiting for ready to return
module usart_tx_arbiter
    import usart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int LATCH_TIMEOUT = USART_LATCH_TIMEOUT_DEF
) (
    input  logic                            comm_clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [USART_BYTE_W*NUM_REQ-1:0] req_data,
`ifdef USART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]              req_lock,
`endif
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [USART_ID_W-1:0]           grant_id,
    output logic                            busy,
    output logic                            timeout_err,
    output logic [USART_BYTE_W-1:0]         tx_data,
    output logic                            tx_latch,
    input  logic                            tx_ready
);

    localparam int                 CNT_W = $clog2(LATCH_TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE   = NUM_REQ'(1);

    usart_state_e            state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    rdy_s;
    logic [USART_ID_W-1:0]   ptr_q, ptr_d, grant_q, grant_d, pick_id, win_id;
    logic                    pick_found;
    logic [USART_BYTE_W-1:0] data_q, data_d, sel_data;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d, done_q, done_d;
`ifdef USART_TX_ARB_LOCK_EN
    logic                    lock_q, lock_d, lock_eff;
`endif

    assign rdy_s = sync_q[SYNC_STAGES-1];

    usart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .winner_o (pick_id),
        .found_o  (pick_found)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ack_d    = '0;
        done_d   = '0;
        win_id   = pick_id;
        sel_data = '0;
`ifdef USART_TX_ARB_LOCK_EN
        // Lock is sampled while done pulses and held until the next grant.
        lock_eff = lock_q | (|(done_q & req_lock));
        if (lock_eff && (|(req_valid & (ONE << grant_q))))
            win_id = grant_q;
        lock_d   = (state_q == IDLE) && lock_eff && !(pick_found && rdy_s);
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == USART_ID_W'(i))
                sel_data = req_data[i*USART_BYTE_W +: USART_BYTE_W];
        end

        case (state_q)
            IDLE: begin
                if (pick_found && rdy_s) begin
                    state_d = LATCH;
                    data_d  = sel_data;
                    grant_d = win_id;
                    ack_d   = ONE << win_id;
                    ptr_d   = (win_id == USART_ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                    cnt_d   = '0;
                end
            end
            LATCH: begin
                if (!rdy_s) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q >= CNT_W'(LATCH_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    cnt_d   = CNT_W'(LATCH_TIMEOUT);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (rdy_s) begin
                    state_d = IDLE;
                    done_d  = ONE << grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge comm_clock) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
`ifdef USART_TX_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tx_ready};
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
`ifdef USART_TX_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign req_ack     = ack_q;
    assign req_done    = done_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;
    assign tx_data     = data_q;
    assign tx_latch    = (state_q == LATCH);

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Self-checking bench for usart_tx_arbiter with a behavioural transmitter
// model and an ack/done scoreboard.
`timescale 1ns/1ps
module tb_usart_tx_arbiter;

    logic        comm_clock = 1'b0;
    logic        reset      = 1'b1;
    logic [3:0]  req_valid  = '0;
    logic [31:0] req_data   = '0;
`ifdef USART_TX_ARB_LOCK_EN
    logic [3:0]  req_lock   = '0;
`endif
    logic [3:0]  req_ack, req_done;
    logic [2:0]  grant_id;
    logic        busy, timeout_err, tx_latch;
    logic [7:0]  tx_data;
    logic        tx_ready   = 1'b1;

    always #5 comm_clock = ~comm_clock;

    usart_tx_arbiter #(.NUM_REQ(4), .SYNC_STAGES(2), .LATCH_TIMEOUT(8)) dut (
        .comm_clock  (comm_clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
`ifdef USART_TX_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .req_ack     (req_ack),
        .req_done    (req_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .tx_data     (tx_data),
        .tx_latch    (tx_latch),
        .tx_ready    (tx_ready)
    );

    typedef struct { int id; logic [7:0] data; } exp_t;
    exp_t exp_ack_q[$];
    int   exp_done_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   acks_seen = 0;
    logic model_stuck = 1'b0;
    logic [7:0] model_byte = '0;

    // Transmitter model: goes busy a few cycles after seeing latch, then idles.
    initial begin
        forever begin
            @(negedge comm_clock);
            if (!model_stuck && tx_latch === 1'b1 && tx_ready === 1'b1) begin
                repeat (3) @(negedge comm_clock);
                model_byte = tx_data;
                tx_ready   = 1'b0;
                repeat (10) @(negedge comm_clock);
                tx_ready   = 1'b1;
            end
        end
    end

    always @(negedge comm_clock) begin : monitor
        exp_t e;
        int   d;
        if (!reset) begin
            if (req_ack !== 4'b0000) begin
                acks_seen++;
                checks++;
                if (exp_ack_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: req_ack=%b grant_id=%0d, required no ack", req_ack, grant_id);
                end else begin
                    e = exp_ack_q.pop_front();
                    if (req_ack !== (4'b0001 << e.id) || grant_id !== 3'(e.id) || tx_data !== e.data) begin
                        errors++;
                        $display("FAIL ack_grant: req_ack=%b grant_id=%0d tx_data=%h, required ack=%b id=%0d data=%h",
                                 req_ack, grant_id, tx_data, 4'b0001 << e.id, e.id, e.data);
                    end
                    exp_done_q.push_back(e.id);
                end
            end
            if (req_done !== 4'b0000) begin
                checks++;
                if (exp_done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: req_done=%b, required no done", req_done);
                end else begin
                    d = exp_done_q.pop_front();
                    if (req_done !== (4'b0001 << d)) begin
                        errors++;
                        $display("FAIL done_id: req_done=%b, required %b", req_done, 4'b0001 << d);
                    end
                end
            end
        end
    end

    task automatic wait_acks(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge comm_clock);
            if (exp_ack_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge comm_clock);
            if (exp_ack_q.size() == 0 && exp_done_q.size() == 0 && busy === 1'b0 && tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge comm_clock);
        checks++;
        if ({req_ack, req_done, grant_id, busy, timeout_err, tx_data, tx_latch} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b done=%b id=%0d busy=%b err=%b data=%h latch=%b, required all 0",
                     req_ack, req_done, grant_id, busy, timeout_err, tx_data, tx_latch);
        end
        reset = 1'b0;
        repeat (3) @(negedge comm_clock);
        checks++;
        if (busy !== 1'b0 || req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: busy=%b ack=%b with no requests, required 0/0000", busy, req_ack);
        end
    endtask

    task automatic test_single();
        bit ok;
        bit early;
        int n;
        req_data[7:0] = 8'hA5;
        exp_ack_q.push_back('{0, 8'hA5});
        req_valid = 4'b0001;
        @(negedge comm_clock);
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL single_ack_latency: req_ack=%b one cycle after valid, required 0001", req_ack);
        end
        checks++;
        if (tx_latch !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_latch: latch=%b data=%h busy=%b, required 1/a5/1", tx_latch, tx_data, busy);
        end
        req_valid = 4'b0000;
        early = 1'b0;
        n = 0;
        while (tx_ready === 1'b1 && n < 50) begin
            if (tx_latch !== 1'b1) early = 1'b1;
            @(negedge comm_clock);
            n++;
        end
        checks++;
        if (early || n >= 50) begin
            errors++;
            $display("FAIL single_latch_hold: dropped_early=%b cycles=%0d, required latch held until ready falls", early, n);
        end
        n = 0;
        while (tx_latch === 1'b1 && n < 50) begin
            @(negedge comm_clock);
            n++;
        end
        checks++;
        if (model_byte !== 8'hA5 || tx_latch !== 1'b0) begin
            errors++;
            $display("FAIL single_tx_byte: byte=%h latch=%b, required a5/0", model_byte, tx_latch);
        end
        wait_drain(ok);
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: drained=%0d busy=%b, required done seen and busy 0", ok, busy);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int a0;
        reset = 1'b1;
        @(negedge comm_clock);
        reset = 1'b0;
        repeat (3) @(negedge comm_clock);
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
        for (int k = 0; k < 5; k++) exp_ack_q.push_back('{k % 4, 8'h10 + 8'(k % 4)});
        a0 = acks_seen;
        req_valid = 4'b1111;
        wait_acks(ok);
        req_valid = 4'b0000;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_acks: %0d grants outstanding, required 0", exp_ack_q.size());
        end
        wait_drain(ok);
        checks++;
        if (!ok || acks_seen - a0 != 5) begin
            errors++;
            $display("FAIL rr_ack_count: acks=%0d drained=%0d, required 5 and drained", acks_seen - a0, ok);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        req_data[7:0]  = 8'h20;
        req_data[15:8] = 8'h21;
        exp_ack_q.push_back('{1, 8'h21});
        req_valid = 4'b0010;
        wait_acks(ok);
        req_valid = 4'b0000;
        wait_drain(ok);
        checks++;
        if (!ok || grant_id !== 3'd1) begin
            errors++;
            $display("FAIL wrap_setup: drained=%0d grant_id=%0d, required drained and 1", ok, grant_id);
        end
        exp_ack_q.push_back('{0, 8'h20});
        exp_ack_q.push_back('{1, 8'h21});
        req_valid = 4'b0011;
        wait_acks(ok);
        req_valid = 4'b0000;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_order: %0d grants outstanding, required 0", exp_ack_q.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        model_stuck = 1'b1;
        req_data[23:16] = 8'h42;
        exp_ack_q.push_back('{2, 8'h42});
        req_valid = 4'b0100;
        n = 0;
        while (req_ack === 4'b0000 && n < 20) begin
            @(negedge comm_clock);
            n++;
        end
        req_valid = 4'b0000;
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL timeout_grant: no ack within %0d cycles, required ack", n);
        end
        n = 0;
        while (tx_latch === 1'b1 && n < 100) begin
            @(negedge comm_clock);
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL timeout_len: latch high %0d cycles, required 8", n);
        end
        exp_done_q.delete();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: err=%b busy=%b, required 1/0", timeout_err, busy);
        end
        model_stuck = 1'b0;
        req_data[31:24] = 8'h43;
        exp_ack_q.push_back('{3, 8'h43});
        req_valid = 4'b1000;
        wait_acks(ok);
        req_valid = 4'b0000;
        wait_drain(ok);
        checks++;
        if (!ok || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: drained=%0d err=%b, required drained and err 1", ok, timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        req_data[15:8] = 8'h51;
        exp_ack_q.push_back('{1, 8'h51});
        req_valid = 4'b0010;
        wait_acks(ok);
        req_valid = 4'b0000;
        n = 0;
        while (!(busy === 1'b1 && tx_latch === 1'b0) && n < 50) begin
            @(negedge comm_clock);
            n++;
        end
        reset = 1'b1;
        exp_done_q.delete();
        @(negedge comm_clock);
        reset = 1'b0;
        checks++;
        if (n >= 50 || {busy, tx_latch, req_done, req_ack, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid: wait=%0d busy=%b latch=%b done=%b ack=%b err=%b, required WAIT_DONE reached and all 0",
                     n, busy, tx_latch, req_done, req_ack, timeout_err);
        end
        n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            @(negedge comm_clock);
            n++;
        end
        req_data[7:0]   = 8'h50;
        req_data[23:16] = 8'h52;
        exp_ack_q.push_back('{0, 8'h50});
        req_valid = 4'b0101;
        wait_acks(ok);
        req_valid = 4'b0000;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_ptr: %0d grants outstanding, required requester 0 served", exp_ack_q.size());
        end
    endtask

`ifdef USART_TX_ARB_LOCK_EN
    task automatic test_lock();
        bit ok;
        int n;
        req_data[15:8]  = 8'h61;
        req_data[23:16] = 8'h62;
        for (int k = 0; k < 3; k++) exp_ack_q.push_back('{1, 8'h61});
        exp_ack_q.push_back('{2, 8'h62});
        req_lock  = 4'b0010;
        req_valid = 4'b0110;
        n = 0;
        while (exp_ack_q.size() > 1 && n < 500) begin
            @(negedge comm_clock);
            n++;
        end
        req_lock = 4'b0000;
        wait_acks(ok);
        req_valid = 4'b0000;
        wait_drain(ok);
        checks++;
        if (n >= 500 || !ok) begin
            errors++;
            $display("FAIL lock_order: %0d grants outstanding, required 1,1,1,2 served", exp_ack_q.size());
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_reset_mid();
`ifdef USART_TX_ARB_LOCK_EN
        test_lock();
`endif
        repeat (5) @(negedge comm_clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
